// File: rtl/cpc_ramexp_pkg.sv
// -----------------------------------------------------------------------------
// cpc_ramexp_pkg
// Shared types, constants and the page-mapping helper for the CPC RAM
// expansion controller (cpc_ramexp_cfg_port, cpc_ramexp_ctrl).
//   cfg_state_e  : config-port capture FSM states
//   page_map_t   : {hit, blk[1:0]} result of map_page()
//   map_page()   : Gate Array RAM-config mode + Z80 page -> expansion block
// -----------------------------------------------------------------------------
package cpc_ramexp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAPT   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    // Gate Array is selected by A15=0, A14=1; RAM-config writes carry tag 11.
    localparam logic [1:0] GA_PORT_A15_14 = 2'b01;
    localparam logic [1:0] CFG_TAG        = 2'b11;

    typedef struct packed {
        logic       hit;
        logic [1:0] blk;
    } page_map_t;

    // Expansion blocks 4-7 of the Gate Array scheme are blocks 0-3 of the
    // selected 64K bank. Mode 3 maps page 3 only; the page-1 view of internal
    // block 3 is left to the host RAM.
    function automatic page_map_t map_page(input logic [2:0] mode,
                                           input logic [1:0] page);
        page_map_t m;
        m.hit = 1'b0;
        m.blk = 2'd0;
        case (mode)
            3'd0: ;
            3'd1, 3'd3: begin
                if (page == 2'd3) begin
                    m.hit = 1'b1;
                    m.blk = 2'd3;
                end
            end
            3'd2: begin
                m.hit = 1'b1;
                m.blk = page;
            end
            default: begin
                if (page == 2'd1) begin
                    m.hit = 1'b1;
                    m.blk = mode[1:0];
                end
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cpc_ramexp_cfg_port.sv
// -----------------------------------------------------------------------------
// cpc_ramexp_cfg_port
// Snoops Gate Array RAM-config writes and holds the active configuration.
//   CLK, RESET_B          : bus clock, async active-low reset
//   A[15:0], D[7:0]       : Z80 address / data (D observed only)
//   IOREQ_B, WR_B, M1_B   : Z80 I/O strobes
//   cfg_mode[2:0]         : committed RAM-config mode
//   cfg_bank[BANK_W-1:0]  : committed 64K bank index
// -----------------------------------------------------------------------------
module cpc_ramexp_cfg_port
    import cpc_ramexp_pkg::*;
#(
    parameter int BANK_W = 4
) (
    input  logic              CLK,
    input  logic              RESET_B,
    input  logic [15:0]       A,
    input  logic [7:0]        D,
    input  logic              IOREQ_B,
    input  logic              WR_B,
    input  logic              M1_B,
    output logic [2:0]        cfg_mode,
    output logic [BANK_W-1:0] cfg_bank
);

    cfg_state_e        state_q, state_d;
    logic              iowr;
    logic              capture_en;
    logic              commit_en;
    logic [2:0]        pend_mode;
    logic [BANK_W-1:0] pend_bank;
    logic [5:0]        bank_ext;
    logic              unused_ok;

    // M1_B low with IOREQ_B low is an interrupt acknowledge, never a write.
    assign iowr = !IOREQ_B && !WR_B && M1_B
               && (A[15:14] == GA_PORT_A15_14)
               && (D[7:6] == CFG_TAG);

    // Upper bank bits come from the inverted port address (0x7F -> 0,
    // 0x7E -> 1, ...). Bits beyond BANK_W drop out, so the index wraps.
    assign bank_ext  = {~A[10:8], D[5:3]};
    assign unused_ok = ^{A[13:11], A[7:0], bank_ext};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        capture_en = 1'b0;
        commit_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iowr) begin
                    capture_en = 1'b1;
                    state_d    = CAPT;
                end
            end
            CAPT: begin
                if (IOREQ_B || WR_B) state_d = COMMIT;
            end
            COMMIT: begin
                commit_en = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q   <= IDLE;
            pend_mode <= '0;
            pend_bank <= '0;
            cfg_mode  <= '0;
            cfg_bank  <= '0;
        end else begin
            state_q <= state_d;
            if (capture_en) begin
                pend_mode <= D[2:0];
                pend_bank <= bank_ext[BANK_W-1:0];
            end
            if (commit_en) begin
                cfg_mode <= pend_mode;
                cfg_bank <= pend_bank;
            end
        end
    end

endmodule

// File: rtl/cpc_ramexp_ctrl.sv
// -----------------------------------------------------------------------------
// cpc_ramexp_ctrl
// CPC RAM expansion core: maps Z80 16K pages onto 1..8 x 512K SRAMs.
//   CLK, RESET_B                  : bus clock, async active-low reset
//   A, D, MREQ_B, IOREQ_B, RD_B,
//   WR_B, M1_B, RFSH_B            : Z80 bus (all inputs)
//   HIADR[4:0]                    : SRAM A18..A14 = {bank[2:0], blk}
//   RAMCS_B[NUM_SRAM-1:0]         : one-cold chip selects
//   RAMOE_B, RAMWE_B              : SRAM output / write enables
//   RAMDIS                        : high disables CPC internal RAM
//   DIP[3:0] (CPC_RAMEXP_DIP_EN)  : board switches; [0] disable, [1] 6128
// Optional feature macro: CPC_RAMEXP_DIP_EN.
// NUM_SRAM legal values: 1, 2, 4, 8.
// -----------------------------------------------------------------------------
module cpc_ramexp_ctrl
    import cpc_ramexp_pkg::*;
#(
    parameter int NUM_SRAM = 2
) (
    input  logic                CLK,
    input  logic                RESET_B,
    input  logic [15:0]         A,
    input  logic [7:0]          D,
    input  logic                MREQ_B,
    input  logic                IOREQ_B,
    input  logic                RD_B,
    input  logic                WR_B,
    input  logic                M1_B,
    input  logic                RFSH_B,
`ifdef CPC_RAMEXP_DIP_EN
    input  logic [3:0]          DIP,
`endif
    output logic [4:0]          HIADR,
    output logic [NUM_SRAM-1:0] RAMCS_B,
    output logic                RAMOE_B,
    output logic                RAMWE_B,
    output logic                RAMDIS
);

    localparam int BANK_W = 3 + $clog2(NUM_SRAM);
    localparam logic [NUM_SRAM-1:0] CS_ONE = NUM_SRAM'(1);

    logic [2:0]        cfg_mode;
    logic [BANK_W-1:0] cfg_bank;
    logic [BANK_W-1:0] chip_sel;
    logic [2:0]        eff_mode;
    page_map_t         pmap;
    logic              exp_off;
    logic              mode_6128;
    logic              mem_hit;
    logic [4:0]        hiadr_q;

    cpc_ramexp_cfg_port #(
        .BANK_W (BANK_W)
    ) u_cfg_port (
        .CLK      (CLK),
        .RESET_B  (RESET_B),
        .A        (A),
        .D        (D),
        .IOREQ_B  (IOREQ_B),
        .WR_B     (WR_B),
        .M1_B     (M1_B),
        .cfg_mode (cfg_mode),
        .cfg_bank (cfg_bank)
    );

`ifdef CPC_RAMEXP_DIP_EN
    logic [1:0] dip_meta, dip_sync;
    logic       unused_dip;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            dip_meta <= '0;
            dip_sync <= '0;
        end else begin
            dip_meta <= DIP[1:0];
            dip_sync <= dip_meta;
        end
    end

    // DIP[3:2] are reserved switches.
    assign unused_dip = ^DIP[3:2];
    assign exp_off    = dip_sync[0];
    assign mode_6128  = dip_sync[1];
`else
    assign exp_off   = 1'b0;
    assign mode_6128 = 1'b0;
`endif

    // Chip index is the bank above the 8 banks held by one 512K SRAM.
    assign chip_sel = cfg_bank >> 3;

    always_comb begin
        // cfg keeps tracking while disabled, so re-enabling needs no new OUT.
        eff_mode = exp_off ? 3'd0 : cfg_mode;
        pmap     = map_page(eff_mode, A[15:14]);
        // In 6128 mode bank 0 is the internal second 64K.
        mem_hit  = !MREQ_B && RFSH_B && pmap.hit
                && !(mode_6128 && (cfg_bank == '0));

        RAMDIS  = 1'b0;
        RAMCS_B = '1;
        RAMOE_B = 1'b1;
        RAMWE_B = 1'b1;
        HIADR   = hiadr_q;
        if (mem_hit) begin
            RAMDIS  = 1'b1;
            RAMCS_B = ~(CS_ONE << chip_sel);
            RAMOE_B = RD_B;
            RAMWE_B = WR_B;
            HIADR   = {cfg_bank[2:0], pmap.blk};
        end
    end

    // HIADR is live during a mapped access and holds the last mapped address
    // otherwise; a register keeps that hold latch-free.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            hiadr_q <= '0;
        end else if (mem_hit) begin
            hiadr_q <= {cfg_bank[2:0], pmap.blk};
        end
    end

endmodule

// File: doc/cpc_ramexp_ctrl.md
Name: cpc_ramexp_ctrl

Overview:
- CPLD core logic for the CPC RAM expansion boards. It is the parametrised successor to the fixed 1MB (2 x 512K SRAM) design.
- Snoops Gate Array RAM-config writes (port 0x7Fxx, data 11bbbccc) and extends the bank number from inverted port address bits.
- Maps Z80 16K pages onto expansion SRAM. Drives SRAM high address, per-chip selects, OE/WE and RAMDIS to the CPC edge connector.
- Scales from 512K to 4MB by chip count.

Parameters:
- NUM_SRAM, 2, number of 512K x 8 SRAMs fitted; legal values 1, 2, 4, 8.
- BANK_W, 3+$clog2(NUM_SRAM), derived (localparam): 64K-bank index width.

Ports:
- CLK  in  1  CPC 4MHz bus clock; all state on rising edge.
- RESET_B  in  1  asynchronous active-low reset (BUSRESET_B from the edge connector).
- A  in  16  Z80 address bus.
- D  in  8  Z80 data bus (input only; the block never drives D).
- MREQ_B  in  1  memory request.
- IOREQ_B  in  1  I/O request.
- RD_B  in  1  read strobe.
- WR_B  in  1  write strobe.
- M1_B  in  1  opcode fetch / interrupt acknowledge.
- RFSH_B  in  1  refresh cycle.
- HIADR  out  5  SRAM A18..A14 = {bank[2:0], blk[1:0]}.
- RAMCS_B  out  NUM_SRAM  one-cold chip select, indexed by bank[BANK_W-1:3].
- RAMOE_B  out  1  SRAM output enable.
- RAMWE_B  out  1  SRAM write enable.
- RAMDIS  out  1  high disables CPC internal RAM.

Behaviour:
- Reset: cfg_mode=0, cfg_bank=0, FSM=IDLE.
  - All RAMCS_B=1, RAMOE_B=1, RAMWE_B=1, RAMDIS=0, HIADR=0.
  - Reset mid-capture discards the pending write; no commit.
- Config write match (iowr), all of:
  - IOREQ_B=0, WR_B=0, M1_B=1;
  - A15=0, A14=1;
  - D[7:6]=2'b11.
  - Interrupt acknowledge (IOREQ_B=0 with M1_B=0) is never a match.
- Captured fields:
  - mode = D[2:0].
  - bank = {~A[8 +: BANK_W-3], D[5:3]}. Port 0x7F selects banks 0-7; 0x7E selects 8-15; and so on.
- FSM, sampled on CLK:
  - IDLE: iowr sampled high -> CAPT. Mode and bank are captured on this edge only; later D/A changes are ignored.
  - CAPT: stays while IOREQ_B=0 and WR_B=0. The first edge sampling either strobe high -> COMMIT.
  - COMMIT: cfg register updated on this edge -> IDLE.
  - The new mapping is effective from the cycle after COMMIT, always before the next Z80 memory cycle.
  - Back-to-back OUTs are each committed in order.
- Page mapping, page = A[15:14]; expansion blocks 4-7 = blocks 0-3 of cfg_bank:
  - mode 0: none.
  - mode 1: page3->blk3.
  - mode 2: pages 0-3->blk0-3.
  - mode 3: page3->blk3 (page1 shows internal block 3; host-handled).
  - modes 4-7: page1->blk(mode-4).
- Memory access (combinational from registered cfg, zero latency): MREQ_B=0, RFSH_B=1, and the page is mapped. When true:
  - RAMDIS=1.
  - HIADR={cfg_bank[2:0], blk}.
  - RAMCS_B[cfg_bank[BANK_W-1:3]]=0.
  - RAMOE_B=RD_B, RAMWE_B=WR_B.
  - Otherwise all inactive and HIADR holds its last value.
- Refresh cycles never assert a chip select.
- Bank index wraps modulo 2^BANK_W; port address bits above BANK_W are ignored.

Optional Feature:
- Macro: CPC_RAMEXP_DIP_EN. Adds input port DIP[3:0] (board switches, pulled low, closed = 1). DIP is sampled through a 2-flop synchroniser.
  - DIP[0]=1: expansion disabled; mapping is treated as mode 0. cfg is still tracked, so re-enabling takes effect immediately.
  - DIP[1]=1: 6128 mode. Bank 0 is served by internal RAM, so the block never asserts RAMDIS/CS for cfg_bank=0.
  - DIP[3:2] reserved; must be ignored.
- Without the macro: no DIP port, behaviour as if DIP=0.

Decomposition:
- Package cpc_ramexp_pkg holds:
  - FSM state enum {IDLE, CAPT, COMMIT};
  - constants GA_PORT_A15_14 = 2'b01 and CFG_TAG = 2'b11;
  - function map_page(mode, page) returning {hit, blk[1:0]}.
- Sub-module cpc_ramexp_cfg_port: iowr decode, FSM and cfg register.
- Top: combinational memory decode plus the optional DIP synchroniser.

Test Plan:
- Reset then memory read at 0xC000 -> RAMDIS=0, all RAMCS_B=1; OUT (0x7FFF),0xC1 then read at 0xC000 -> RAMDIS=1, HIADR=5'b00011, RAMCS_B=2'b10, RAMOE_B follows RD_B.
- OUT (0x7EFF),0xFA (bank 15, mode 2), NUM_SRAM=2 -> write at 0x4000 gives HIADR=5'b11101, RAMCS_B=2'b01, RAMWE_B follows WR_B.
- Interrupt acknowledge with D=0xC2 -> cfg unchanged; refresh cycle at 0xC000 under mode 1 -> no CS asserted.
- RESET_B pulsed low while FSM is in CAPT -> no commit; cfg=0, outputs at reset values asynchronously.
- Mode 4..7 sweep with bank 2 -> 0x4000 maps blk 0..3, pages 0/2/3 stay internal.
- With CPC_RAMEXP_DIP_EN: DIP=4'b0010, OUT 0xC2 (bank 0) -> RAMDIS stays 0; OUT 0xCA (bank 1) -> RAMDIS=1. DIP=4'b0001 -> RAMDIS never asserts.
